// File: rtl/serial_out_rx_pkg.sv
// Shared definitions for the serial_out_rx receiver: FSM states and frame constants.
package serial_out_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_out_rx_byte_fifo.sv
// First-word-fall-through byte FIFO with a separate occupancy count.
module byte_fifo #(
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned PW         = $clog2(FIFO_DEPTH),
  localparam int unsigned CW         = PW + 1
) (
  input  logic          clock,
  input  logic          input_nclear,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign head  = mem_q[rd_q];
  assign count = count_q;

  // A push into a full FIFO only lands when a pop frees a slot in the same cycle.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + PW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + PW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Storage, pointers and count registers.
  always_ff @(posedge clock or negedge input_nclear) begin
    if (!input_nclear) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serial_out_rx.sv
// UART-style receiver for the CPU serial output: synchroniser, framing FSM,
// shift register and a small receive FIFO with a valid/ready read side.
module serial_out_rx
  import serial_out_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                          clock,
  input  logic                          input_nclear,
  input  logic                          serial_in,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_error,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned     BW   = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]           sync_q, sync_d;
  logic                 s_line;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;
  logic                 push;
  logic                 fifo_full, fifo_empty;

  assign s_line = sync_q[1];

  // Two-flop synchroniser on the incoming line.
  always_comb begin
    sync_d = {sync_q[0], serial_in};
  end

  always_ff @(posedge clock or negedge input_nclear) begin
    if (!input_nclear) sync_q <= {2{IDLE_LEVEL}};
    else               sync_q <= sync_d;
  end

  // Framing FSM next-state: start validation, data sampling, stop check.
  // The IDLE detection cycle is offset 0 of the start bit, so START compares
  // cnt+1 against the mid point; with a mid point of 0 the detection itself is
  // the start sample and START is skipped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (s_line != IDLE_LEVEL) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = (MID == '0) ? ST_DATA : ST_START;
        end
      end
      ST_START: begin
        if (cnt_q + CNT_W'(1) == MID) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = (s_line != IDLE_LEVEL) ? ST_DATA : ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {s_line, shift_q[DATA_BITS-1:1]};
          if (bit_q == BW'(DATA_BITS - 1)) state_d = ST_STOP;
          else                             bit_d   = bit_q + BW'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (s_line == IDLE_LEVEL) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BREAK: begin
        if (s_line == IDLE_LEVEL) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A completed byte is lost only when the FIFO is full and not popped this cycle.
  always_comb begin
    ovr_d = push & fifo_full & ~(rx_valid & rx_ready);
  end

  // FSM, counters, shift register and registered pulse outputs.
  always_ff @(posedge clock or negedge input_nclear) begin
    if (!input_nclear) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock        (clock),
    .input_nclear (input_nclear),
    .push         (push),
    .push_data    (shift_q),
    .pop          (rx_ready),
    .head         (rx_data),
    .count        (fifo_count),
    .full         (fifo_full),
    .empty        (fifo_empty)
  );

  assign rx_valid    = ~fifo_empty;
  assign frame_error = fe_q;
  assign overrun     = ovr_q;

endmodule
